// File: rtl/vga_timing_gen.sv
// 800x600 VGA raster timing generator: frame-buffer read coordinates, pixel-clock-enabled
// counters, and a ce-gated alignment pipeline so that sync and colour reach the pins together.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned H_FP        = 56,
  parameter int unsigned H_SYNC      = 120,
  parameter int unsigned H_BP        = 64,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned V_FP        = 37,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 23,
  parameter logic        HSYNC_POL   = 1'b1,
  parameter logic        VSYNC_POL   = 1'b1,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [10:0] x,
  output logic [9:0]  y,
  input  logic [11:0] colour_in,
  output logic        frame_trig,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [MEM_LATENCY-1:0] r_de_pipe;
  logic [MEM_LATENCY-1:0] r_hs_pipe;
  logic [MEM_LATENCY-1:0] r_vs_pipe;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_trig;
  logic [11:0] r_rgb;

  logic w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_de, w_hs, w_vs;

  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);
    w_h_act  = (r_h_cnt < H_ACT);
    w_v_act  = (r_v_cnt < V_ACT);
    w_de     = w_h_act && w_v_act;
    w_hs     = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    w_vs     = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    x        = w_h_act ? r_h_cnt : '0;
    y        = w_v_act ? r_v_cnt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_ce) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  // Stage count matches the frame buffer latency, so the last stage lines up with colour_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de_pipe <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
      r_hsync   <= ~HSYNC_POL;
      r_vsync   <= ~VSYNC_POL;
      r_rgb     <= '0;
    end else if (pix_ce) begin
      r_de_pipe[0] <= w_de;
      r_hs_pipe[0] <= w_hs;
      r_vs_pipe[0] <= w_vs;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        r_de_pipe[i] <= r_de_pipe[i-1];
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
      r_hsync <= r_hs_pipe[MEM_LATENCY-1] ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= r_vs_pipe[MEM_LATENCY-1] ? VSYNC_POL : ~VSYNC_POL;
      r_rgb   <= r_de_pipe[MEM_LATENCY-1] ? colour_in : '0;
    end
  end

  // High for the single clk in which the counters sit at (0, V_ACTIVE) after advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_frame_trig <= 1'b0;
    else      r_frame_trig <= pix_ce && w_h_wrap && (r_v_cnt == V_ACT_LAST);
  end

  assign frame_trig = r_frame_trig;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign vga_r      = r_rgb[11:8];
  assign vga_g      = r_rgb[7:4];
  assign vga_b      = r_rgb[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster; expected outputs are derived
// arithmetically from the number of pix_ce edges since reset release.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
  localparam int VA = 10, VFP = 2, VSW = 3, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b0;
  logic [11:0] colour_in = '0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        frame_trig, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .MEM_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y), .colour_in(colour_in),
    .frame_trig(frame_trig), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // Frame buffer model: one pixel-clock of read latency.
  always @(posedge clk) if (pix_ce) colour_in <= {x[3:0], y[3:0], 4'hA};

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        ft;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Expected pins after cnt pixel-clock advances; sync/colour lag the raster by two.
  function automatic exp_t model(input int cnt, input logic trig);
    exp_t e;
    int h, v, ph, pv;
    h = cnt % HT;
    v = (cnt / HT) % VT;
    e.x   = (h < HA) ? 11'(h) : 11'd0;
    e.y   = (v < VA) ? 10'(v) : 10'd0;
    e.hs  = 1'b0;
    e.vs  = 1'b0;
    e.rgb = 12'h000;
    e.ft  = trig;
    if (cnt >= 2) begin
      ph = (cnt - 2) % HT;
      pv = ((cnt - 2) / HT) % VT;
      e.hs = (ph >= HA + HFP) && (ph < HA + HFP + HSW);
      e.vs = (pv >= VA + VFP) && (pv < VA + VFP + VSW);
      if (ph < HA && pv < VA) e.rgb = {4'(ph), 4'(pv), 4'hA};
    end
    return e;
  endfunction

  task automatic check(input exp_t e, input string tag);
    vectors++;
    if (x !== e.x) begin
      miscompares++;
      $display("FAIL %s x: got %0d want %0d at %0t", tag, x, e.x, $time);
    end
    if (y !== e.y) begin
      miscompares++;
      $display("FAIL %s y: got %0d want %0d at %0t", tag, y, e.y, $time);
    end
    if (hsync !== e.hs) begin
      miscompares++;
      $display("FAIL %s hsync: got %b want %b at %0t", tag, hsync, e.hs, $time);
    end
    if (vsync !== e.vs) begin
      miscompares++;
      $display("FAIL %s vsync: got %b want %b at %0t", tag, vsync, e.vs, $time);
    end
    if ({vga_r, vga_g, vga_b} !== e.rgb) begin
      miscompares++;
      $display("FAIL %s rgb: got %h want %h at %0t", tag, {vga_r, vga_g, vga_b}, e.rgb, $time);
    end
    if (frame_trig !== e.ft) begin
      miscompares++;
      $display("FAIL %s frame_trig: got %b want %b at %0t", tag, frame_trig, e.ft, $time);
    end
  endtask

  task automatic step(input logic ce);
    logic trig;
    pix_ce = ce;
    @(posedge clk);
    trig = 1'b0;
    if (!rst) n = 0;
    else if (ce) begin
      n++;
      trig = (n % HT == 0) && ((n / HT) % VT == VA);
    end
    sb.push_back(model(n, trig));
    #1;
  endtask

  // Monitor: one expectation per clk, compared away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check(mon_e, "raster");
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1);
    rst = 1'b1;

    for (int i = 0; i < 2 * HT * VT + 40; i++) step(1'b1);
    for (int i = 0; i < 2 * HT * 6; i++) step(i % 2 == 0);
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 2) != 0);

    for (int i = 0; i < HT * VT && !(n % HT == HA / 2 && (n / HT) % VT == VA / 2); i++)
      step(1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check(model(0, 1'b0), "reset_async");
    for (int i = 0; i < 3; i++) step(1'b1);
    rst = 1'b1;

    for (int i = 0; i < HT * VT + 60; i++) step(1'b1);
    for (int i = 0; i < 1200; i++) step($urandom_range(0, 3) != 0);

    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
